// File: rtl/max_pool_sched_if.sv
// Handshake and RAM-side bundle for the time-multiplexed max-pool scheduler.
interface max_pool_sched_if #(
    parameter int unsigned N  = 32,
    parameter int unsigned K  = 2,
    parameter int unsigned AW = $clog2(N * N),
    parameter int unsigned RW = ((N / K) > 1) ? $clog2(N / K) : 1
);
    logic          start;
    logic          busy;
    logic          done;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [7:0]    rd_data;
    logic          out_valid;
    logic          out_ready;
    logic [7:0]    out_data;
    logic [RW-1:0] out_row;
    logic [RW-1:0] out_col;

    // Scheduler view
    modport master (
        input  start, rd_data, out_ready,
        output busy, done, rd_en, rd_addr, out_valid, out_data, out_row, out_col
    );

    // Frame buffer / downstream view
    modport slave (
        output start, rd_data, out_ready,
        input  busy, done, rd_en, rd_addr, out_valid, out_data, out_row, out_col
    );
endinterface

// File: rtl/max_pool_sched.sv
// Time-multiplexed max-pool scheduler: one comparator walks every KxK window
// of an NxN frame held in a 1-cycle-latency RAM and emits one max per window.
module max_pool_sched #(
    parameter int unsigned N  = 32,
    parameter int unsigned K  = 2,
    parameter int unsigned AW = $clog2(N * N)
) (
    input  logic              clk,
    input  logic              rst,
    max_pool_sched_if.master  bus
);

    localparam int unsigned NW = N / K;
    localparam int unsigned RW = (NW > 1) ? $clog2(NW) : 1;
    localparam int unsigned KW = (K > 1) ? $clog2(K) : 1;

    localparam logic [RW-1:0] W_LAST = RW'(NW - 1);
    localparam logic [KW-1:0] K_LAST = KW'(K - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_LAST,
        S_OUT,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [RW-1:0] i_q, i_d, j_q, j_d;
    logic [KW-1:0] m_q, m_d, n_q, n_d;
    logic [7:0]    max_q, max_d;
    logic          pending_q;

    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          rd_en_q, rd_en_d;
    logic [AW-1:0] rd_addr_q, rd_addr_d;
    logic          out_valid_q, out_valid_d;
    logic [7:0]    out_data_q, out_data_d;
    logic [RW-1:0] out_row_q, out_row_d;
    logic [RW-1:0] out_col_q, out_col_d;

    // Next-state, counter walk, running max and registered-output next values
    always_comb begin
        state_d    = state_q;
        i_d        = i_q;
        j_d        = j_q;
        m_d        = m_q;
        n_d        = n_q;
        max_d      = (pending_q && (bus.rd_data > max_q)) ? bus.rd_data : max_q;
        out_data_d = out_data_q;
        out_row_d  = out_row_q;
        out_col_d  = out_col_q;

        case (state_q)
            S_IDLE: begin
                i_d   = '0;
                j_d   = '0;
                m_d   = '0;
                n_d   = '0;
                max_d = '0;
                if (bus.start) begin
                    state_d = S_READ;
                end
            end
            S_READ: begin
                if ((m_q == K_LAST) && (n_q == K_LAST)) begin
                    state_d = S_LAST;
                end else if (n_q == K_LAST) begin
                    n_d = '0;
                    m_d = m_q + KW'(1);
                end else begin
                    n_d = n_q + KW'(1);
                end
            end
            S_LAST: begin
                // Final read data lands this cycle; capture the window result.
                state_d    = S_OUT;
                out_data_d = max_d;
                out_row_d  = i_q;
                out_col_d  = j_q;
            end
            S_OUT: begin
                if (bus.out_ready) begin
                    if ((i_q == W_LAST) && (j_q == W_LAST)) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_READ;
                        m_d     = '0;
                        n_d     = '0;
                        max_d   = '0;
                        if (j_q == W_LAST) begin
                            j_d = '0;
                            i_d = i_q + RW'(1);
                        end else begin
                            j_d = j_q + RW'(1);
                        end
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        rd_en_d     = (state_d == S_READ);
        rd_addr_d   = rd_en_d ? AW'((32'(i_d) * K + 32'(m_d)) * N + 32'(j_d) * K + 32'(n_d))
                              : rd_addr_q;
        busy_d      = (state_d == S_READ) || (state_d == S_LAST) || (state_d == S_OUT);
        done_d      = (state_d == S_DONE);
        out_valid_d = (state_d == S_OUT);
    end

    // State, counters, accumulator and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            i_q         <= '0;
            j_q         <= '0;
            m_q         <= '0;
            n_q         <= '0;
            max_q       <= '0;
            pending_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rd_en_q     <= 1'b0;
            rd_addr_q   <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_row_q   <= '0;
            out_col_q   <= '0;
        end else begin
            state_q     <= state_d;
            i_q         <= i_d;
            j_q         <= j_d;
            m_q         <= m_d;
            n_q         <= n_d;
            max_q       <= max_d;
            pending_q   <= rd_en_q;
            busy_q      <= busy_d;
            done_q      <= done_d;
            rd_en_q     <= rd_en_d;
            rd_addr_q   <= rd_addr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_row_q   <= out_row_d;
            out_col_q   <= out_col_d;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.rd_en     = rd_en_q;
    assign bus.rd_addr   = rd_addr_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_row   = out_row_q;
    assign bus.out_col   = out_col_q;

endmodule

// File: tb/tb_max_pool_sched.sv
// Scoreboard bench for max_pool_sched with N=4, K=2.
module tb_max_pool_sched;

    localparam int unsigned N = 4;
    localparam int unsigned K = 2;

    typedef struct {
        int data;
        int row;
        int col;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    max_pool_sched_if #(.N(N), .K(K)) bus();

    max_pool_sched #(.N(N), .K(K)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Single-port RAM model, 1-cycle read latency
    logic [7:0] mem [16];
    always @(posedge clk) begin
        if (bus.rd_en) bus.rd_data <= mem[bus.rd_addr];
    end

    int   addr_q [$];
    exp_t out_q  [$];
    exp_t mon_e;

    int checks    = 0;
    int failures  = 0;
    int neg_cnt   = 0;
    int n0        = 0;
    int done_cnt  = 0;
    bit lat_armed = 1'b0;
    bit done_armed = 1'b0;

    int seq [16] = '{0, 1, 4, 5, 2, 3, 6, 7, 8, 9, 12, 13, 10, 11, 14, 15};

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic push_out(input int d, input int r, input int c);
        exp_t e;
        e.data = d;
        e.row  = r;
        e.col  = c;
        out_q.push_back(e);
    endtask

    task automatic push_addrs(input int count);
        for (int a = 0; a < count; a++) addr_q.push_back(seq[a]);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_busy"},      int'(bus.busy),      0);
        chk({tag, "_done"},      int'(bus.done),      0);
        chk({tag, "_rd_en"},     int'(bus.rd_en),     0);
        chk({tag, "_rd_addr"},   int'(bus.rd_addr),   0);
        chk({tag, "_out_valid"}, int'(bus.out_valid), 0);
        chk({tag, "_out_data"},  int'(bus.out_data),  0);
        chk({tag, "_out_row"},   int'(bus.out_row),   0);
        chk({tag, "_out_col"},   int'(bus.out_col),   0);
    endtask

    task automatic start_pulse(input bit arm);
        @(posedge clk);
        #1 bus.start = 1'b1;
        @(posedge clk);
        n0         = neg_cnt;
        lat_armed  = arm;
        done_armed = arm;
        #1 bus.start = 1'b0;
    endtask

    task automatic wait_done(input int target);
        int k;
        k = 0;
        while (done_cnt < target && k < 300) begin
            @(posedge clk);
            k++;
        end
        chk("done_seen", done_cnt, target);
        repeat (4) @(posedge clk);
        chk("done_once", done_cnt, target);
        chk("addr_q_empty", addr_q.size(), 0);
        chk("out_q_empty", out_q.size(), 0);
    endtask

    // Monitor: read addresses, output handshakes, done pulses and latencies
    always @(negedge clk) begin
        neg_cnt++;
        if (bus.rd_en) begin
            if (addr_q.size() == 0) chk("rd_unexpected", int'(bus.rd_addr), -1);
            else chk("rd_addr", int'(bus.rd_addr), addr_q.pop_front());
        end
        if (bus.out_valid && lat_armed) begin
            chk("first_valid_lat", neg_cnt - n0, 6);
            lat_armed = 1'b0;
        end
        if (bus.out_valid && bus.out_ready) begin
            if (out_q.size() == 0) begin
                chk("out_unexpected", int'(bus.out_data), -1);
            end else begin
                mon_e = out_q.pop_front();
                chk("out_data", int'(bus.out_data), mon_e.data);
                chk("out_row",  int'(bus.out_row),  mon_e.row);
                chk("out_col",  int'(bus.out_col),  mon_e.col);
            end
        end
        if (bus.done) begin
            done_cnt++;
            if (done_armed) begin
                chk("done_lat", neg_cnt - n0, 25);
                done_armed = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired actual=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        int k;
        bus.start     = 1'b0;
        bus.out_ready = 1'b0;

        // Reset held three cycles: everything quiet
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero("reset");
        @(posedge clk);
        #1 rst = 1'b0;

        // Frame A: pixel = address, ready high, spurious start mid-frame
        for (int a = 0; a < 16; a++) mem[a] = 8'(a);
        bus.out_ready = 1'b1;
        push_addrs(16);
        push_out(5, 0, 0);
        push_out(7, 0, 1);
        push_out(13, 1, 0);
        push_out(15, 1, 1);
        start_pulse(1'b1);
        @(negedge clk);
        chk("busy_high", int'(bus.busy), 1);
        repeat (6) @(posedge clk);
        #1 bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        wait_done(1);
        chk("busy_low_after", int'(bus.busy), 0);

        // Frame B: unsigned compare, zero / 0xFF windows, equal maxima, stall
        mem[0]  = 8'h80; mem[1]  = 8'hFF; mem[4]  = 8'h01; mem[5]  = 8'h7F;
        mem[2]  = 8'h00; mem[3]  = 8'h00; mem[6]  = 8'h00; mem[7]  = 8'h00;
        mem[8]  = 8'hFF; mem[9]  = 8'hFF; mem[12] = 8'hFF; mem[13] = 8'hFF;
        mem[10] = 8'h03; mem[11] = 8'h09; mem[14] = 8'h09; mem[15] = 8'h02;
        bus.out_ready = 1'b0;
        push_addrs(16);
        push_out(255, 0, 0);
        push_out(0, 0, 1);
        push_out(255, 1, 0);
        push_out(9, 1, 1);
        start_pulse(1'b0);
        k = 0;
        while (!bus.out_valid && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("valid_seen", int'(bus.out_valid), 1);
        repeat (10) begin
            @(negedge clk);
            chk("stall_valid", int'(bus.out_valid), 1);
            chk("stall_data",  int'(bus.out_data),  255);
            chk("stall_row",   int'(bus.out_row),   0);
            chk("stall_col",   int'(bus.out_col),   0);
            chk("stall_rd_en", int'(bus.rd_en),     0);
        end
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
        wait_done(2);

        // Frame C: reset during READ of window (1,0), after address 8 issued
        for (int a = 0; a < 16; a++) mem[a] = 8'(a);
        push_addrs(9);
        push_out(5, 0, 0);
        push_out(7, 0, 1);
        start_pulse(1'b0);
        repeat (13) @(posedge clk);
        #1 rst = 1'b1;
        #1 check_zero("midrst");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (5) @(posedge clk);
        chk("midrst_no_done", done_cnt, 2);
        chk("midrst_addr_q_empty", addr_q.size(), 0);
        chk("midrst_out_q_empty", out_q.size(), 0);

        // Frame D: full re-run after the abandoned frame
        push_addrs(16);
        push_out(5, 0, 0);
        push_out(7, 0, 1);
        push_out(13, 1, 0);
        push_out(15, 1, 1);
        start_pulse(1'b1);
        wait_done(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
